// File: rtl/reg_ex2mem_if.sv
// EX->MEM pipeline register bundle: hazard controls, EX-side inputs
// and MEM-side registered outputs.
interface reg_ex2mem_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              stall;
    logic              flush;
    logic [DATA_W-1:0] PC_next_EX;
    logic [DATA_W-1:0] PC_next_MEM;
    logic              MemtoReg_EX;
    logic              MemtoReg_MEM;
    logic              RegWrite_EX;
    logic              RegWrite_MEM;
    logic [ADDR_W-1:0] writeAddr_EX;
    logic [ADDR_W-1:0] writeAddr_MEM;
    logic [DATA_W-1:0] ALU_result_EX;
    logic [DATA_W-1:0] ALU_result_MEM;

    modport master (
        output stall, flush,
        output PC_next_EX, MemtoReg_EX, RegWrite_EX,
        output writeAddr_EX, ALU_result_EX,
        input  PC_next_MEM, MemtoReg_MEM, RegWrite_MEM,
        input  writeAddr_MEM, ALU_result_MEM
    );

    modport slave (
        input  stall, flush,
        input  PC_next_EX, MemtoReg_EX, RegWrite_EX,
        input  writeAddr_EX, ALU_result_EX,
        output PC_next_MEM, MemtoReg_MEM, RegWrite_MEM,
        output writeAddr_MEM, ALU_result_MEM
    );
endinterface

// File: rtl/reg_ex2mem.sv
// EX->MEM pipeline register of the 5-stage MIPS core, with stall
// (hold) and flush (bubble) controls from the hazard unit.
module reg_ex2mem #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    reg_ex2mem_if.slave     bus
);
    typedef struct packed {
        logic [DATA_W-1:0] pc_next;
        logic [DATA_W-1:0] alu_result;
        logic [ADDR_W-1:0] write_addr;
        logic              mem_to_reg;
        logic              reg_write;
    } ex_mem_t;

    ex_mem_t d;
    ex_mem_t q;

    always_comb begin
        d            = '0;
        d.pc_next    = bus.PC_next_EX;
        d.alu_result = bus.ALU_result_EX;
        d.write_addr = bus.writeAddr_EX;
        d.mem_to_reg = bus.MemtoReg_EX;
        d.reg_write  = bus.RegWrite_EX;
    end

    // One flop bank for every field, so no field can update while another holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (bus.flush) begin
            q <= '0;
        end else if (!bus.stall) begin
            q <= d;
        end
    end

    assign bus.PC_next_MEM    = q.pc_next;
    assign bus.ALU_result_MEM = q.alu_result;
    assign bus.writeAddr_MEM  = q.write_addr;
    assign bus.MemtoReg_MEM   = q.mem_to_reg;
    assign bus.RegWrite_MEM   = q.reg_write;
endmodule

// File: tb/tb_reg_ex2mem.sv
// Directed and randomised bench for the EX->MEM pipeline register.
// Outputs are packed {PC, ALU, addr, MemtoReg, RegWrite} for comparison.
module tb_reg_ex2mem;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    reg_ex2mem_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    reg_ex2mem #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [70:0] outs();
        return {bus.PC_next_MEM, bus.ALU_result_MEM, bus.writeAddr_MEM,
                bus.MemtoReg_MEM, bus.RegWrite_MEM};
    endfunction

    function automatic logic [70:0] vec(input logic [31:0] pc,
                                        input logic [31:0] alu,
                                        input logic [4:0] wa,
                                        input logic m2r,
                                        input logic rw);
        return {pc, alu, wa, m2r, rw};
    endfunction

    task automatic drive(input logic st, input logic fl,
                         input logic [31:0] pc, input logic [31:0] alu,
                         input logic [4:0] wa, input logic m2r,
                         input logic rw);
        bus.stall         = st;
        bus.flush         = fl;
        bus.PC_next_EX    = pc;
        bus.ALU_result_EX = alu;
        bus.writeAddr_EX  = wa;
        bus.MemtoReg_EX   = m2r;
        bus.RegWrite_EX   = rw;
    endtask

    task automatic test_reset();
        logic [70:0] exp;
        #1;
        vectors++;
        if (outs() !== '0) begin
            miscompares++;
            $display("FAIL reset_initial: got %h want 0", outs());
        end
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 32'h11112222, 32'h33334444, 5'd9, 1, 1);
        exp = vec(32'h11112222, 32'h33334444, 5'd9, 1, 1);
        @(posedge clk); #1;
        vectors++;
        if (outs() !== exp) begin
            miscompares++;
            $display("FAIL reset_preload: got %h want %h", outs(), exp);
        end
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (outs() !== '0) begin
            miscompares++;
            $display("FAIL reset_async: got %h want 0", outs());
        end
        @(posedge clk); #1;
        vectors++;
        if (outs() !== '0) begin
            miscompares++;
            $display("FAIL reset_held: got %h want 0", outs());
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (outs() !== '0) begin
            miscompares++;
            $display("FAIL reset_release: got %h want 0", outs());
        end
        @(posedge clk); #1;
        vectors++;
        if (outs() !== exp) begin
            miscompares++;
            $display("FAIL reset_first_edge: got %h want %h", outs(), exp);
        end
    endtask

    task automatic test_pass_through();
        logic [70:0] exp;
        @(negedge clk);
        drive(0, 0, 32'h00400004, 32'habc12345, 5'd3, 0, 1);
        exp = vec(32'h00400004, 32'habc12345, 5'd3, 0, 1);
        @(posedge clk); #1;
        vectors++;
        if (outs() !== exp) begin
            miscompares++;
            $display("FAIL pass_through: got %h want %h", outs(), exp);
        end
    endtask

    task automatic test_pipelining();
        logic [31:0] alu_tab [4];
        logic [70:0] prev;
        logic [70:0] cur;
        alu_tab[0] = 32'habc12345;
        alu_tab[1] = 32'h30663220;
        alu_tab[2] = 32'h12345678;
        alu_tab[3] = 32'hdeadbeef;
        prev = vec(32'h00400004, 32'habc12345, 5'd3, 0, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(0, 0, 32'h00400008 + 32'(i * 4), alu_tab[i],
                  5'(i), i[0], 1'b1);
            cur = vec(32'h00400008 + 32'(i * 4), alu_tab[i],
                      5'(i), i[0], 1'b1);
            #1;
            vectors++;
            if (outs() !== prev) begin
                miscompares++;
                $display("FAIL pipe_before_%0d: got %h want %h", i, outs(), prev);
            end
            @(posedge clk); #1;
            vectors++;
            if (outs() !== cur) begin
                miscompares++;
                $display("FAIL pipe_after_%0d: got %h want %h", i, outs(), cur);
            end
            prev = cur;
        end
    endtask

    task automatic test_stall();
        logic [70:0] a;
        logic [70:0] d;
        @(negedge clk);
        drive(0, 0, 32'h0000a000, 32'h0000a001, 5'd10, 1, 0);
        a = vec(32'h0000a000, 32'h0000a001, 5'd10, 1, 0);
        @(posedge clk);
        @(negedge clk);
        drive(1, 0, 32'h0000b000, 32'h0000b001, 5'd11, 0, 1);
        @(posedge clk); #1;
        vectors++;
        if (outs() !== a) begin
            miscompares++;
            $display("FAIL stall_edge1: got %h want %h", outs(), a);
        end
        @(negedge clk);
        drive(1, 0, 'x, 'x, 'x, 1'bx, 1'bx);
        @(posedge clk); #1;
        vectors++;
        if (outs() !== a) begin
            miscompares++;
            $display("FAIL stall_edge2_x: got %h want %h", outs(), a);
        end
        @(negedge clk);
        drive(0, 0, 32'h0000d000, 32'h0000d001, 5'd13, 1, 1);
        d = vec(32'h0000d000, 32'h0000d001, 5'd13, 1, 1);
        @(posedge clk); #1;
        vectors++;
        if (outs() !== d) begin
            miscompares++;
            $display("FAIL stall_release: got %h want %h", outs(), d);
        end
        @(negedge clk);
        bus.stall = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (outs() !== '0) begin
            miscompares++;
            $display("FAIL stall_reset: got %h want 0", outs());
        end
        @(negedge clk);
        rst = 1'b0;
        bus.stall = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (outs() !== d) begin
            miscompares++;
            $display("FAIL stall_reset_reload: got %h want %h", outs(), d);
        end
    endtask

    task automatic test_flush();
        @(negedge clk);
        drive(0, 1, 32'h00400100, 32'h00001000, 5'd31, 1, 1);
        @(posedge clk); #1;
        vectors++;
        if (outs() !== '0) begin
            miscompares++;
            $display("FAIL flush: got %h want 0", outs());
        end
        @(negedge clk);
        drive(0, 0, 32'h00400200, 32'h00002000, 5'd7, 1, 1);
        @(posedge clk);
        @(negedge clk);
        drive(1, 1, 32'h00400300, 32'h00003000, 5'd8, 1, 1);
        @(posedge clk); #1;
        vectors++;
        if (outs() !== '0) begin
            miscompares++;
            $display("FAIL flush_over_stall: got %h want 0", outs());
        end
        @(negedge clk);
        drive(0, 1, 'x, 'x, 'x, 1'bx, 1'bx);
        @(posedge clk); #1;
        vectors++;
        if (outs() !== '0) begin
            miscompares++;
            $display("FAIL flush_x: got %h want 0", outs());
        end
    endtask

    task automatic test_random();
        logic [70:0] exp;
        logic [70:0] in_v;
        logic        st;
        logic        fl;
        exp = '0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            st = ($urandom_range(3) == 0);
            fl = ($urandom_range(7) == 0);
            in_v = {$urandom(), $urandom(), 5'($urandom()),
                    1'($urandom()), 1'($urandom())};
            drive(st, fl, in_v[70:39], in_v[38:7], in_v[6:2],
                  in_v[1], in_v[0]);
            rst = (i == 0) || ($urandom_range(19) == 0);
            #1;
            if (rst) exp = '0;
            vectors++;
            if (outs() !== exp) begin
                miscompares++;
                $display("FAIL rand_mid_%0d: got %h want %h", i, outs(), exp);
            end
            @(posedge clk); #1;
            if (rst || fl) exp = '0;
            else if (!st) exp = in_v;
            vectors++;
            if (outs() !== exp) begin
                miscompares++;
                $display("FAIL rand_edge_%0d: got %h want %h", i, outs(), exp);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        drive(0, 0, 32'h0, 32'h0, 5'd0, 0, 0);
        test_reset();
        test_pass_through();
        test_pipelining();
        test_stall();
        test_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
